// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// The sum is DATA_W+1 bits wide so the carry is kept in its MSB.
package adder_sched_pkg;

  localparam int DATA_W   = 8;
  localparam int SUM_W    = DATA_W + 1;
  localparam int MAX_ID_W = 4;   // wide enough for up to 16 requesters

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [SUM_W-1:0]    sum;
  } rsp_t;

  // Advance the round-robin pointer, wrapping at n-1 back to 0.
  function automatic logic [MAX_ID_W-1:0] next_ptr(input logic [MAX_ID_W-1:0] ptr,
                                                   input int n);
    if (int'(ptr) >= n - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/adder_rr_sched_rr_arb.sv
// Combinational round-robin arbiter: the first set request at or above ptr
// wins, wrapping from NUM_REQ-1 to 0. Produces a one-hot grant and its index.
module rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic          found;
  logic [ID_W:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, ptr} + (ID_W+1)'(i);
      if (j >= (ID_W+1)'(NUM_REQ)) j = j - (ID_W+1)'(NUM_REQ);
      if (en && !found && req[j[ID_W-1:0]]) begin
        found               = 1'b1;
        gnt[j[ID_W-1:0]]    = 1'b1;
        idx                 = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered adder between NUM_REQ clients.
// Result appears one cycle after the accepting edge, tagged with the client id.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = adder_sched_pkg::DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W:0]           rsp_sum,
  output logic [ID_W-1:0]           rsp_id,
  output logic [15:0]               ops_cnt
);

  // Handshake: a beat moves on a rising edge where valid && ready. Requesters
  // hold valid and operands until accepted; ready never depends on being held.
  // The response register stays frozen while rsp_valid && !rsp_ready.
  logic [ID_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               slot_free;
  logic               xfer;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  rsp_t               rsp_q;

  assign slot_free = !rsp_valid || rsp_ready;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (slot_free && !rst),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign a_sel     = req_a[gnt_idx*DATA_W +: DATA_W];
  assign b_sel     = req_b[gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      ptr_q     <= '0;
      ops_cnt   <= '0;
    end else begin
      if (xfer) begin
        rsp_valid <= 1'b1;
        rsp_q.sum <= SUM_W'(a_sel) + SUM_W'(b_sel);
        rsp_q.id  <= MAX_ID_W'(gnt_idx);
        ptr_q     <= ID_W'(next_ptr(MAX_ID_W'(gnt_idx), NUM_REQ));
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready) ops_cnt <= ops_cnt + 16'd1;
    end
  end

  assign rsp_sum = rsp_q.sum;
  assign rsp_id  = ID_W'(rsp_q.id);

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: grant order, carry, backpressure,
// pointer wrap and asynchronous reset, with a queue of expected responses.
module tb_adder_rr_sched;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*8-1:0] req_a;
  logic [N*8-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [8:0]    rsp_sum;
  logic [1:0]    rsp_id;
  logic [15:0]   ops_cnt;

  logic [7:0]    a_op [N];
  logic [7:0]    b_op [N];
  logic [10:0]   exp_q [$];   // {id[1:0], sum[8:0]}

  int n_assert = 0;
  int n_fail   = 0;

  assign req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
  assign req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

  adder_rr_sched #(.NUM_REQ(N), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .ops_cnt   (ops_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the grant vector and, if a grant is expected, queue its result.
  task automatic grant_chk(input string tag, input logic [N-1:0] exp_rdy);
    logic [8:0] s;
    chk(tag, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        s = {1'b0, a_op[i]} + {1'b0, b_op[i]};
        exp_q.push_back({2'(i), s});
      end
    end
  endtask

  task automatic rsp_chk(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed response with no expected entry, expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_sum"},   32'(rsp_sum),   32'(e[8:0]));
      chk({tag, "_id"},    32'(rsp_id),    32'(e[10:9]));
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_op[i] = a;
    b_op[i] = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 8'h00, 8'h00);
    #12;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sum",   32'(rsp_sum),   32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_ops",   32'(ops_cnt),   32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    req_valid = '0;
    tick();

    // single request from requester 2
    set_op(2, 8'h12, 8'h34);
    req_valid = 4'b0100;
    settle();
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_sum",   32'(rsp_sum),   32'h046);
    chk("single_id",    32'(rsp_id),    32'd2);
    rsp_ready = 1'b1;
    tick();
    chk("single_ops",   32'(ops_cnt),   32'd1);
    chk("single_drain", 32'(rsp_valid), 32'd0);

    // all four requesting continuously, from a fresh pointer
    reset_pulse();
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h11 * (i + 1)), 8'(i + 1));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      grant_chk($sformatf("rr_grant%0d", k), 4'(1 << (k % 4)));
      tick();
      rsp_chk($sformatf("rr_rsp%0d", k));
    end
    req_valid = '0;
    tick();
    chk("rr_ops",   32'(ops_cnt),   32'd8);
    chk("rr_drain", 32'(rsp_valid), 32'd0);

    // carry into the MSB
    set_op(0, 8'hFF, 8'hFF);
    req_valid = 4'b0001;
    settle();
    grant_chk("carry_g0", 4'b0001);
    tick();
    chk("carry_ff", 32'(rsp_sum), 32'h1FE);
    set_op(1, 8'h80, 8'h80);
    req_valid = 4'b0010;
    settle();
    grant_chk("carry_g1", 4'b0010);
    tick();
    chk("carry_80", 32'(rsp_sum), 32'h100);
    exp_q.delete();
    req_valid = '0;
    tick();
    chk("carry_ops", 32'(ops_cnt), 32'd10);

    // backpressure with requesters 1 and 3 pending (pointer at 2)
    rsp_ready = 1'b0;
    set_op(0, 8'h05, 8'h06);
    req_valid = 4'b0001;
    settle();
    grant_chk("bp_g0", 4'b0001);
    tick();
    rsp_chk("bp_first");
    set_op(1, 8'h21, 8'h01);
    set_op(3, 8'h30, 8'h03);
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_sum%0d", k),   32'(rsp_sum),   32'h00B);
      chk($sformatf("bp_id%0d", k),    32'(rsp_id),    32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    settle();
    grant_chk("bp_rel_g1", 4'b0010);
    tick();
    chk("bp_rel_ops1", 32'(ops_cnt), 32'd11);
    rsp_chk("bp_rel_rsp1");
    req_valid = 4'b1000;
    settle();
    grant_chk("bp_rel_g3", 4'b1000);
    tick();
    chk("bp_rel_ops2", 32'(ops_cnt), 32'd12);
    rsp_chk("bp_rel_rsp3");

    // pointer wrap after grant 3, then skip over idle requester 1
    set_op(0, 8'h01, 8'h02);
    set_op(2, 8'h03, 8'h04);
    req_valid = 4'b0101;
    settle();
    grant_chk("wrap_g0", 4'b0001);
    tick();
    rsp_chk("wrap_rsp0");
    settle();
    grant_chk("wrap_g2", 4'b0100);
    tick();
    rsp_chk("wrap_rsp2");
    settle();
    chk("wrap_g0_again", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();
    chk("wrap_ops", 32'(ops_cnt), 32'd15);

    // async reset mid-cycle with a pending result and ops_cnt=5
    reset_pulse();
    set_op(0, 8'h07, 8'h08);
    req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    settle();
    chk("ar_pre_valid", 32'(rsp_valid), 32'd1);
    chk("ar_pre_ops",   32'(ops_cnt),   32'd5);
    #1;
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("ar_valid", 32'(rsp_valid), 32'd0);
    chk("ar_ops",   32'(ops_cnt),   32'd0);
    chk("ar_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    settle();
    chk("ar_first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
Round-robin scheduler that shares one registered 8-bit add stage between NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester per cycle and returns the 9-bit sum, tagged with the requester ID, on a single response port. It sits between client engines and the shared adder resource, and it owns backpressure and fairness.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, operand width; sum is DATA_W+1 bits
ID_W, $clog2(NUM_REQ), requester tag width (derived, not overridable)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accept
rsp_sum  out  DATA_W+1  a+b, unsigned, carry in MSB
rsp_id  out  ID_W  index of requester that produced rsp_sum
ops_cnt  out  16  count of completed responses (rsp_valid&&rsp_ready), wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync deassert by the surrounding system):
  - rsp_valid=0, rsp_sum=0, rsp_id=0, ops_cnt=0.
  - Priority pointer = 0, so requester 0 has top priority.
  - req_ready=0 while rst is high.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant:
  - Computed combinationally when slot_free.
  - Winner is the first requester with req_valid set, searching from the pointer upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[winner]=1; all other ready bits are 0.
  - No grant when !slot_free or when no request is valid.
- Transfer: req_valid[i] && req_ready[i] at a rising edge transfers the operands.
  - Next cycle: rsp_valid=1, rsp_sum=a+b zero-extended to DATA_W+1, rsp_id=i.
  - Latency is exactly 1 cycle.
- Pointer update: on each transfer, pointer <= (winner+1) mod NUM_REQ. With no transfer, the pointer holds.
- Response hold: while rsp_valid && !rsp_ready, rsp_sum and rsp_id are stable and all req_ready=0.
- Same-cycle drain and accept: rsp_valid && rsp_ready with a new transfer in the same cycle means the register reloads with the new result and rsp_valid stays 1. Full throughput is 1 op/cycle.
- Drain with no new request: rsp_ready with no transfer clears rsp_valid the next cycle. rsp_sum/rsp_id keep their last values (don't-care).
- Counter: ops_cnt increments on each rsp_valid && rsp_ready and wraps modulo 2^16.
- Arithmetic: unsigned only, with no overflow loss (e.g. 0xFF+0xFF=0x1FE).
- Fairness: any continuously asserted request is granted within NUM_REQ transfers.
- Requester-side rule: requesters must hold req_valid/operands until accepted. The scheduler does not check this.
- Reset mid-operation: any pending result is discarded immediately, and the pointer and counter are cleared.

Decomposition:
- Package adder_sched_pkg holds:
  - DATA_W default and the SUM_W = DATA_W+1 localparam;
  - the rsp_t struct {id, sum};
  - the function next_ptr(ptr, n).
- One sub-module, rr_arb:
  - parameters NUM_REQ;
  - inputs req vector, pointer, enable;
  - outputs one-hot grant and encoded index, purely combinational.
- The top level holds:
  - the pointer register;
  - the output register, which contains the add;
  - the counter;
  - operand muxing.

Test Plan:
- Reset, then single request: req_valid=4'b0100, a=0x12, b=0x34 -> req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_sum=0x046, rsp_id=2; ops_cnt=1 after rsp_ready.
- All four requesting continuously, rsp_ready=1:
  - required grant order 0,1,2,3,0,...
  - one rsp per cycle;
  - rsp_id sequence matches;
  - ops_cnt=8 after 8 cycles.
- Carry: a=0xFF, b=0xFF -> rsp_sum=0x1FE; a=0x80, b=0x80 -> 0x100.
- Backpressure: rsp_ready=0 for 5 cycles with requests 1 and 3 pending:
  - req_ready=0 throughout;
  - rsp_sum/rsp_id unchanged;
  - on release, requester 1 is granted, then 3.
- Pointer wrap and skip: last grant=3, then req_valid=4'b0101 -> grant 0, then 2.
- Async reset asserted mid-cycle while rsp_valid=1 and ops_cnt=0x0005:
  - rsp_valid drops without waiting for clk;
  - ops_cnt=0;
  - after release with all requesting, the first grant is 0.
